// File: rtl/sram_responder.sv
// Synthesizable stand-in for the board SRAM: the responder end of the 16-bit SRAM bus.
// Writes are captured on the edge where SRAM_WE_N is low. Reads are returned onto the
// shared bus after READ_LAT edges. The responder stays off the bus for TURNAROUND edges
// after a write, and until read data has been produced.
module sram_responder #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_addr,
  input  logic              SRAM_WE_N,
  inout  wire  [15:0]       SRAM_data,
  output logic              rd_valid,
  output logic              drive_en,
  output logic              oob_err,
  output logic [15:0]       wr_count
);

  localparam int unsigned Words    = 1 << DEPTH_LOG2;
  localparam logic [1:0]  TurnInit = 2'(TURNAROUND);

  logic [15:0]           mem [Words];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_en;
  logic                  rd_req;
  logic                  oob_hit;

  // Pipeline exit: the request whose data is loaded into rd_data at this edge.
  logic                  exit_v;
  logic [DEPTH_LOG2-1:0] exit_idx;
  logic [15:0]           exit_word;

  logic [15:0]           rd_data;
  logic [1:0]            turn_cnt;
  logic                  rd_valid_seen;

  assign idx    = SRAM_addr[DEPTH_LOG2-1:0];
  assign wr_en  = ~SRAM_WE_N;
  assign rd_req = SRAM_WE_N;

  // Address bits above the implemented depth only raise the sticky flag; the access aliases.
  if (ADDR_W > DEPTH_LOG2) begin : g_oob
    assign oob_hit = |SRAM_addr[ADDR_W-1:DEPTH_LOG2];
  end else begin : g_no_oob
    assign oob_hit = 1'b0;
  end

  // Read request pipeline. With READ_LAT=1 the exit is the request being sampled now.
  if (READ_LAT == 1) begin : g_lat1
    assign exit_v   = rd_req;
    assign exit_idx = idx;
  end else begin : g_pipe
    logic                  pipe_v   [READ_LAT-1];
    logic [DEPTH_LOG2-1:0] pipe_idx [READ_LAT-1];

    // Shift read requests toward the exit; a write edge inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < READ_LAT - 1; i++) begin
          pipe_v[i]   <= 1'b0;
          pipe_idx[i] <= '0;
        end
      end else begin
        pipe_v[0]   <= rd_req;
        pipe_idx[0] <= idx;
        for (int unsigned i = 1; i < READ_LAT - 1; i++) begin
          pipe_v[i]   <= pipe_v[i-1];
          pipe_idx[i] <= pipe_idx[i-1];
        end
      end
    end

    assign exit_v   = pipe_v[READ_LAT-2];
    assign exit_idx = pipe_idx[READ_LAT-2];
  end

  // Array write port; contents survive reset, writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[idx] <= SRAM_data;
    end
  end

  // Read word for the exiting request, forwarding a same-edge write to the same word.
  always_comb begin
    exit_word = mem[exit_idx];
    if (wr_en && (exit_idx == idx)) begin
      exit_word = SRAM_data;
    end
  end

  // Read data, turnaround counter and debug status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data       <= 16'h0000;
      rd_valid      <= 1'b0;
      turn_cnt      <= TurnInit;
      rd_valid_seen <= 1'b0;
      oob_err       <= 1'b0;
      wr_count      <= 16'h0000;
    end else begin
      rd_valid <= exit_v;
      if (exit_v) begin
        rd_data <= exit_word;
      end

      if (wr_en) begin
        turn_cnt <= TurnInit;
      end else if (turn_cnt != 2'd0) begin
        turn_cnt <= turn_cnt - 2'd1;
      end

      // A write invalidates whatever was last presented; wait for fresh read data.
      if (wr_en) begin
        rd_valid_seen <= 1'b0;
      end else if (rd_valid) begin
        rd_valid_seen <= 1'b1;
      end

      if (oob_hit) begin
        oob_err <= 1'b1;
      end

      if (wr_en && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // SRAM_WE_N is used directly so the bus is released in the same cycle a write starts.
  assign drive_en  = SRAM_WE_N & (turn_cnt == 2'd0) & (rd_valid | rd_valid_seen);
  assign SRAM_data = drive_en ? rd_data : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed bus cycles, a transaction-level model of the SRAM
// checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_sram_responder;

  localparam int AW = 18;
  localparam int DL = 16;
  localparam int RL = 2;
  localparam int TA = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [15:0]   tb_data = 16'h0000;
  logic          tb_drive = 1'b0;
  wire  [15:0]   bus;
  logic          rd_valid;
  logic          drive_en;
  logic          oob_err;
  logic [15:0]   wr_count;

  assign bus = tb_drive ? tb_data : 16'hzzzz;

  sram_responder #(
    .ADDR_W    (AW),
    .DEPTH_LOG2(DL),
    .READ_LAT  (RL),
    .TURNAROUND(TA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_addr(addr),
    .SRAM_WE_N(we_n),
    .SRAM_data(bus),
    .rd_valid (rd_valid),
    .drive_en (drive_en),
    .oob_err  (oob_err),
    .wr_count (wr_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int due;
    int idx;
  } req_t;

  req_t        rq[$];
  logic [15:0] mmem [int];
  int          ecount;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_known;
  int          m_idle;   // read edges since the last write (or reset), capped at TA
  logic        m_seen;   // read data produced since the last write (or reset)
  logic        m_oob;
  int          m_wrc;

  task automatic model_reset();
    rq.delete();
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_known = 1'b1;
    m_idle  = 0;
    m_seen  = 1'b0;
    m_oob   = 1'b0;
    m_wrc   = 0;
  endtask

  task automatic model_edge();
    int   i;
    req_t r;
    ecount++;
    i = int'(addr) % (1 << DL);
    if ((addr >> DL) != 0) m_oob = 1'b1;
    if (!we_n) begin
      mmem[i] = bus;
      if (m_wrc < 65535) m_wrc++;
      m_idle = 0;
      m_seen = 1'b0;
    end else begin
      if (m_idle < TA) m_idle++;
      rq.push_back('{due: ecount + RL - 1, idx: i});
    end
    // Writes land before the due read looks up memory, which gives forwarding.
    m_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == ecount) begin
      r = rq.pop_front();
      m_valid = 1'b1;
      m_seen  = 1'b1;
      if (mmem.exists(r.idx)) begin
        m_data  = mmem[r.idx];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
  endtask

  initial begin
    ecount = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_edge();
    end
  end

  // Per-cycle compare against the model, away from the clock edge.
  initial forever begin
    logic exp_drive;
    @(posedge clk);
    #2;
    if (rst) begin
      exp_drive = we_n && (m_idle >= TA) && m_seen;
      check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
      check("drive_en", {31'b0, drive_en}, {31'b0, exp_drive});
      check("oob_err", {31'b0, oob_err}, {31'b0, m_oob});
      check("wr_count", {16'b0, wr_count}, m_wrc);
      if (m_known) check("rd_data", {16'b0, dut.rd_data}, {16'b0, m_data});
      if (exp_drive && m_known) check("bus_data", {16'b0, bus}, {16'b0, m_data});
    end
  end

  // One bus cycle: inputs change on the falling edge, returns just after the rising edge.
  task automatic do_cycle(input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    we_n     = w;
    addr     = a;
    tb_data  = d;
    tb_drive = ~w;
    if (!w) begin
      #1;
      check("no_drive_during_write", {31'b0, drive_en}, 32'd0);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3 rst = 1'b0;
    #1;
    check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("reset_drive_en", {31'b0, drive_en}, 32'd0);
    check("reset_oob", {31'b0, oob_err}, 32'd0);
    check("reset_wr_count", {16'b0, wr_count}, 32'd0);
    check("reset_rd_data", {16'b0, dut.rd_data}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;

    // Write 1234 to 5, read it back; turnaround of 2 keeps the bus free meanwhile
    do_cycle(1'b0, 18'd5, 16'h1234);
    check("t1_wr_count", {16'b0, wr_count}, 32'd1);
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t1_turnaround", {31'b0, drive_en}, 32'd0);
    check("t1_not_yet_valid", {31'b0, rd_valid}, 32'd0);
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t1_rd_valid", {31'b0, rd_valid}, 32'd1);
    check("t1_drive_en", {31'b0, drive_en}, 32'd1);
    check("t1_bus", {16'b0, bus}, 32'h1234);

    // Back-to-back reads of 0..3 after writing A000..A003
    for (int k = 0; k < 4; k++) do_cycle(1'b0, AW'(k), 16'hA000 + 16'(k));
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b1, AW'((k < 4) ? k : 3), 16'h0000);
      if (k >= 1) begin
        check("t2_seq_data", {16'b0, dut.rd_data}, 32'hA000 + 32'(k - 1));
        check("t2_seq_valid", {31'b0, rd_valid}, 32'd1);
      end
    end

    // Out-of-range write aliases onto word 5
    do_cycle(1'b0, 18'h10005, 16'hBEEF);
    check("t3_oob_set", {31'b0, oob_err}, 32'd1);
    do_cycle(1'b1, 18'd5, 16'h0000);
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t3_alias_bus", {16'b0, bus}, 32'hBEEF);
    check("t3_oob_sticky", {31'b0, oob_err}, 32'd1);

    // Write to 7 at the edge its pending read exits: new data is forwarded
    do_cycle(1'b0, 18'd7, 16'h0001);
    do_cycle(1'b1, 18'd7, 16'h0000);
    do_cycle(1'b0, 18'd7, 16'h00FF);
    check("t4_fwd_data", {16'b0, dut.rd_data}, 32'h00FF);
    check("t4_fwd_valid", {31'b0, rd_valid}, 32'd1);
    check("t4_fwd_no_drive", {31'b0, drive_en}, 32'd0);
    do_cycle(1'b1, 18'd7, 16'h0000);
    do_cycle(1'b1, 18'd7, 16'h0000);
    check("t4_readback", {16'b0, bus}, 32'h00FF);
    check("t4_wr_count", {16'b0, wr_count}, 32'd8);

    // Reset with a read in flight
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t5_pre_valid", {31'b0, rd_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, rd_valid}, 32'd0);
    check("t5_rst_drive", {31'b0, drive_en}, 32'd0);
    check("t5_rst_rd_data", {16'b0, dut.rd_data}, 32'd0);
    check("t5_rst_oob", {31'b0, oob_err}, 32'd0);
    check("t5_rst_wr_count", {16'b0, wr_count}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t5_no_stale_valid", {31'b0, rd_valid}, 32'd0);
    check("t5_no_stale_drive", {31'b0, drive_en}, 32'd0);
    do_cycle(1'b1, 18'd5, 16'h0000);
    check("t5_new_valid", {31'b0, rd_valid}, 32'd1);
    check("t5_new_drive", {31'b0, drive_en}, 32'd1);
    check("t5_new_bus", {16'b0, bus}, 32'hBEEF);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
